// File: rtl/shift_cntr_pkg.sv
// Shared constants and helpers for the shift_cntr Johnson/ring counter.
// Optional feature macro: SHIFT_CNTR_SELF_CORRECT_EN (see shift_cntr.sv).
package shift_cntr_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int unsigned MAX_W = 64;

    // Index-0 pattern; callers size-cast the result down to their own width.
    function automatic logic [MAX_W-1:0] zero_pat(input logic mode, input int unsigned width);
        logic [MAX_W-1:0] pat;
        pat = '0;
        if (mode == MODE_RING && width > 0) begin
            pat[0] = 1'b1;
        end
        return pat;
    endfunction

endpackage

// File: rtl/shift_cntr_decode.sv
// Combinational legality check and sequence-index decode of a shift-counter pattern.
// Optional feature macro: none (SHIFT_CNTR_SELF_CORRECT_EN is handled in shift_cntr).
module shift_cntr_decode
    import shift_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             mode_q,
    output logic             legal,
    output logic [IDX_W-1:0] state_idx
);

    int pop;
    int edges;
    int pos;
    int idx;

    always_comb begin
        pop   = 0;
        edges = 0;
        pos   = 0;
        idx   = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (cnt[i]) begin
                pop = pop + 1;
                pos = i;
            end
        end
        // A Johnson pattern has at most one 0/1 boundary between adjacent bits.
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            if (cnt[i] != cnt[i+1]) begin
                edges = edges + 1;
            end
        end

        if (mode_q == MODE_RING) begin
            legal = (pop == 1);
            idx   = pos;
        end else begin
            legal = (edges <= 1);
            idx   = (cnt[0] || pop == 0) ? pop : 2 * int'(WIDTH) - pop;
        end

        state_idx = legal ? IDX_W'(idx) : '0;
    end

endmodule

// File: rtl/shift_cntr.sv
// WIDTH-bit shift counter, runtime Johnson or ring mode, with load, wrap and error flag.
// Define SHIFT_CNTR_SELF_CORRECT_EN to make an enabled step from an illegal pattern reload Z.
module shift_cntr
    import shift_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [IDX_W-1:0] state_idx,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] z_in;
    logic [WIDTH-1:0] z_cur;
    logic [WIDTH-1:0] step_pat;
    logic             legal;

    assign z_in  = WIDTH'(zero_pat(mode, WIDTH));
    assign z_cur = WIDTH'(zero_pat(mode_q, WIDTH));

    shift_cntr_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .cnt       (cnt_q),
        .mode_q    (mode_q),
        .legal     (legal),
        .state_idx (state_idx)
    );

    // Johnson feeds back the inverted outgoing bit, ring feeds it back unchanged.
    always_comb begin
        step_pat = cnt_q;
        if (dir == DIR_UP) begin
            step_pat = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1] ^ (mode_q == MODE_JOHNSON)};
        end else begin
            step_pat = {cnt_q[0] ^ (mode_q == MODE_JOHNSON), cnt_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        if (rst) begin
            cnt_d  = z_in;
            mode_d = mode;
        end else if (load) begin
            cnt_d  = load_val;
            mode_d = mode;
        end else if (mode != mode_q) begin
            cnt_d  = z_in;
            mode_d = mode;
        end else if (en) begin
`ifdef SHIFT_CNTR_SELF_CORRECT_EN
            if (!legal) begin
                cnt_d = z_cur;
            end else begin
                cnt_d  = step_pat;
                wrap_d = (step_pat == z_cur);
            end
`else
            cnt_d  = step_pat;
            // From a legal pattern only index last (up) or 1 (down) can step into Z.
            wrap_d = legal && (step_pat == z_cur);
`endif
        end
    end

    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        mode_q <= mode_d;
        wrap_q <= wrap_d;
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign err  = ~legal;

endmodule

// File: tb/tb_shift_cntr.sv
// Self-checking bench for shift_cntr (WIDTH=4): vector table through a scoreboard queue,
// plus hand-written multi-cycle sequences. Honours SHIFT_CNTR_SELF_CORRECT_EN.
module tb_shift_cntr;

    localparam int unsigned W  = 4;
    localparam int unsigned IW = 3;

    typedef struct {
        logic          rst;
        logic          en;
        logic          mode;
        logic          dir;
        logic          load;
        logic [W-1:0]  lv;
        logic [W-1:0]  ecnt;
        logic [IW-1:0] eidx;
        logic          ewrap;
        logic          eerr;
        string         name;
    } vec_t;

    typedef struct {
        logic [W-1:0]  cnt;
        logic [IW-1:0] idx;
        logic          wrap;
        logic          err;
        string         name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, en, mode, dir, load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  cnt;
    logic [IW-1:0] state_idx;
    logic          wrap, err;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t vecs[$];
    exp_t sb[$];

    shift_cntr #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .dir       (dir),
        .load      (load),
        .load_val  (load_val),
        .cnt       (cnt),
        .state_idx (state_idx),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic m, input logic d,
                                input logic l, input logic [W-1:0] lv, input logic [W-1:0] c,
                                input logic [IW-1:0] i, input logic wr, input logic er,
                                input string n);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.dir = d; v.load = l; v.lv = lv;
        v.ecnt = c; v.eidx = i; v.ewrap = wr; v.eerr = er; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic m, input logic d,
                         input logic l, input logic [W-1:0] lv);
        rst = r; en = e; mode = m; dir = d; load = l; load_val = lv;
    endtask

    task automatic apply(input vec_t v);
        exp_t x;
        exp_t got;
        drive(v.rst, v.en, v.mode, v.dir, v.load, v.lv);
        x.cnt = v.ecnt; x.idx = v.eidx; x.wrap = v.ewrap; x.err = v.eerr; x.name = v.name;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.name, ".cnt"},  32'(cnt),       32'(got.cnt));
        check({got.name, ".idx"},  32'(state_idx), 32'(got.idx));
        check({got.name, ".wrap"}, 32'(wrap),      32'(got.wrap));
        check({got.name, ".err"},  32'(err),       32'(got.err));
    endtask

    // Single clock step for the hand sequences; returns the sampled wrap.
    task automatic step(input logic r, input logic e, input logic m, input logic d,
                        output logic w);
        drive(r, e, m, d, 1'b0, '0);
        @(posedge clk);
        #1;
        w = wrap;
    endtask

    initial begin
        int   wraps;
        logic w;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Johnson up
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "j_rst0"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "j_rst1"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0, "j_up1"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0011, 2, 0, 0, "j_up2"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0111, 3, 0, 0, "j_up3"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b1111, 4, 0, 0, "j_up4"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b1110, 5, 0, 0, "j_up5"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b1100, 6, 0, 0, "j_up6"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b1000, 7, 0, 0, "j_up7"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0000, 0, 1, 0, "j_up_wrap"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0, "j_up9"));
        // Johnson down
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'h0, 4'b0000, 0, 0, 0, "jd_rst"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b1000, 7, 0, 0, "jd1"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b1100, 6, 0, 0, "jd2"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b1110, 5, 0, 0, "jd3"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b1111, 4, 0, 0, "jd4"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b0111, 3, 0, 0, "jd5"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b0011, 2, 0, 0, "jd6"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b0001, 1, 0, 0, "jd7"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b0000, 0, 1, 0, "jd_wrap"));
        // Ring up, hold, mode change
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "r_rst"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'b0010, 1, 0, 0, "r_up1"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'b0100, 2, 0, 0, "r_up2"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'b1000, 3, 0, 0, "r_up3"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'b0001, 0, 1, 0, "r_wrap"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "r_hold"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "mode_chg"));
        // Illegal load in Johnson mode
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0110, 4'b0110, 0, 0, 1, "ld_ill"));
`ifdef SHIFT_CNTR_SELF_CORRECT_EN
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "ill_fix"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0, "ill_fix2"));
`else
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b1101, 0, 0, 1, "ill_step"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'b1010, 0, 0, 1, "ill_step2"));
`endif
        // Load beats en; then walk down to 0111 and reset over a load
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1100, 4'b1100, 6, 0, 0, "ld_en"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b1110, 5, 0, 0, "pre_rst1"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b1111, 4, 0, 0, "pre_rst2"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 4'b0111, 3, 0, 0, "pre_rst3"));
        vecs.push_back(mk(1, 1, 0, 1, 1, 4'b1010, 4'b0000, 0, 0, 0, "rst_over_ld"));
        // Load absorbs a mode change; ring down; illegal ring pattern
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'b0100, 4'b0100, 2, 0, 0, "ld_mode"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 4'b0010, 1, 0, 0, "r_dn1"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 4'b0001, 0, 1, 0, "r_dn_wrap"));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'b0011, 4'b0011, 0, 0, 1, "r_ill"));

        foreach (vecs[k]) apply(vecs[k]);

        // Two full Johnson periods give exactly two wraps and land back on Z.
        step(1'b1, 1'b0, 1'b0, 1'b0, w);
        wraps = 0;
        for (int i = 0; i < 2 * int'(W) * 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, w);
            if (w) wraps++;
        end
        check("j_period_wraps", 32'(wraps), 32'd2);
        check("j_period_cnt", 32'(cnt), 32'd0);
        // Gaps in en must not advance or pulse wrap.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, w);
            check("hold_wrap", 32'(w), 32'd0);
        end
        check("hold_cnt", 32'(cnt), 32'd0);

        // Two full ring periods going down.
        step(1'b1, 1'b0, 1'b1, 1'b1, w);
        wraps = 0;
        for (int i = 0; i < int'(W) * 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, w);
            if (w) wraps++;
        end
        check("r_period_wraps", 32'(wraps), 32'd2);
        check("r_period_cnt", 32'(cnt), 32'd1);

        // Reset mid-sequence leaves no partial step.
        step(1'b0, 1'b1, 1'b1, 1'b0, w);
        step(1'b1, 1'b1, 1'b1, 1'b0, w);
        check("mid_rst_cnt", 32'(cnt), 32'd1);
        check("mid_rst_idx", 32'(state_idx), 32'd0);
        check("mid_rst_wrap", 32'(w), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
